// File: rtl/conv_pkg.sv
// Shared types for the dilated 1-D convolution scheduler.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DONE
  } state_t;

  // Length is carried at full 32 bits so the validity check sees every bit
  // the job supplied; address arithmetic uses the low ADDR_W bits (ADDR_W <= 32).
  localparam int unsigned CFG_LEN_W = 32;

  typedef struct packed {
    logic [CFG_LEN_W-1:0] len;
    logic [3:0]           stride;
    logic [3:0]           dilation;
  } cfg_t;

endpackage

// File: rtl/conv1d_addr_gen.sv
// Loop counters (oc / p / ic / k) and incremental address arithmetic.
// in_addr = ic*len + p + k*dil and w_addr = (oc*IN_CH+ic)*KSIZE + k are
// tracked as running sums so no multiplier or divider sits in the loop.
module conv1d_addr_gen
  import conv_pkg::*;
#(
  parameter int IN_CH  = 2,
  parameter int OUT_CH = 2,
  parameter int KSIZE  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              adv,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] span,
  input  logic [3:0]        stride,
  input  logic [3:0]        dilation,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              tap_first,
  output logic              tap_last,
  output logic              job_last
);

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(KSIZE - 1);
  localparam logic [ADDR_W-1:0] IC_LAST  = ADDR_W'(IN_CH - 1);
  localparam logic [ADDR_W-1:0] OC_LAST  = ADDR_W'(OUT_CH - 1);
  localparam logic [ADDR_W-1:0] W_PER_OC = ADDR_W'(IN_CH * KSIZE);

  logic [ADDR_W-1:0] p_q, p_d, ic_q, ic_d, k_q, k_d, oc_q, oc_d;
  logic [ADDR_W-1:0] row_q, row_d, tap_q, tap_d, w_q, w_d, wbase_q, wbase_d;
  logic [ADDR_W-1:0] stride_w, dil_w, p_next;
  logic              pos_last;

  assign stride_w = ADDR_W'(stride);
  assign dil_w    = ADDR_W'(dilation);
  assign p_next   = p_q + stride_w;
  // Current position is the last one when the next window would run past the end.
  assign pos_last = (p_next + span) >= len;

  assign tap_first = (ic_q == '0) && (k_q == '0);
  assign tap_last  = (ic_q == IC_LAST) && (k_q == K_LAST);
  assign job_last  = tap_last && pos_last && (oc_q == OC_LAST);
  assign in_addr   = row_q + p_q + tap_q;
  assign w_addr    = w_q;

  // Next-counter logic: k innermost, then ic, then position, then oc.
  always_comb begin
    p_d     = p_q;
    ic_d    = ic_q;
    k_d     = k_q;
    oc_d    = oc_q;
    row_d   = row_q;
    tap_d   = tap_q;
    w_d     = w_q;
    wbase_d = wbase_q;
    if (init) begin
      p_d     = '0;
      ic_d    = '0;
      k_d     = '0;
      oc_d    = '0;
      row_d   = '0;
      tap_d   = '0;
      w_d     = '0;
      wbase_d = '0;
    end else if (adv) begin
      if (k_q != K_LAST) begin
        k_d   = k_q + 1'b1;
        tap_d = tap_q + dil_w;
        w_d   = w_q + 1'b1;
      end else begin
        k_d   = '0;
        tap_d = '0;
        if (ic_q != IC_LAST) begin
          ic_d  = ic_q + 1'b1;
          row_d = row_q + len;
          w_d   = w_q + 1'b1;
        end else begin
          ic_d  = '0;
          row_d = '0;
          if (!pos_last) begin
            p_d = p_next;
            w_d = wbase_q;
          end else begin
            p_d     = '0;
            oc_d    = oc_q + 1'b1;
            wbase_d = wbase_q + W_PER_OC;
            w_d     = w_q + 1'b1;
          end
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      ic_q    <= '0;
      k_q     <= '0;
      oc_q    <= '0;
      row_q   <= '0;
      tap_q   <= '0;
      w_q     <= '0;
      wbase_q <= '0;
    end else begin
      p_q     <= p_d;
      ic_q    <= ic_d;
      k_q     <= k_d;
      oc_q    <= oc_d;
      row_q   <= row_d;
      tap_q   <= tap_d;
      w_q     <= w_d;
      wbase_q <= wbase_d;
    end
  end

endmodule

// File: rtl/conv1d_dil_sched.sv
// Dilated/strided 1-D convolution MAC scheduler: job FSM and handshake.
//   state   | meaning
//   S_IDLE  | waiting for start, config latched on start
//   S_SETUP | span computed, config validated, counters cleared
//   S_RUN   | one MAC op offered per cycle, advances on transfer
//   S_DONE  | one-cycle done pulse
module conv1d_dil_sched
  import conv_pkg::*;
#(
  parameter int IN_CH  = 2,
  parameter int OUT_CH = 2,
  parameter int KSIZE  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len_in,
  input  logic [3:0]        cfg_stride,
  input  logic [3:0]        cfg_dilation,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_first,
  output logic              mac_last,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] out_count
);

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] span, ag_in, ag_w;
  logic              cfg_ok, run, xfer, init, tap_first, tap_last, job_last;

  assign span   = ADDR_W'(cfg_q.dilation) * ADDR_W'(KSIZE - 1);
  assign cfg_ok = (cfg_q.stride != '0) && (cfg_q.dilation != '0) &&
                  (CFG_LEN_W'(span) < cfg_q.len);
  assign run    = (state_q == S_RUN);
  assign xfer   = run && mac_ready;

  conv1d_addr_gen #(
    .IN_CH (IN_CH),
    .OUT_CH(OUT_CH),
    .KSIZE (KSIZE),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .adv      (xfer),
    .len      (cfg_q.len[ADDR_W-1:0]),
    .span     (span),
    .stride   (cfg_q.stride),
    .dilation (cfg_q.dilation),
    .in_addr  (ag_in),
    .w_addr   (ag_w),
    .tap_first(tap_first),
    .tap_last (tap_last),
    .job_last (job_last)
  );

  // Next-state, config latch, error flag and output counter.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    init    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cfg_d   = '{len: CFG_LEN_W'(cfg_len_in), stride: cfg_stride, dilation: cfg_dilation};
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        init = 1'b1;
        if (cfg_ok) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer && tap_last) cnt_d = cnt_q + 1'b1;
        if (xfer && job_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign mac_valid = run;
  assign mac_first = run && tap_first;
  assign mac_last  = run && tap_last;
  assign in_addr   = run ? ag_in : '0;
  assign w_addr    = run ? ag_w : '0;
  assign out_addr  = cnt_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_conv1d_dil_sched.sv
// Directed bench: instance A (IN_CH=OUT_CH=1, KSIZE=3), instance B (defaults).
module tb_conv1d_dil_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        sel = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [3:0]  cfg_stride = '0;
  logic [3:0]  cfg_dilation = '0;

  logic        start_a, start_b;
  logic        a_busy, a_done, a_err, a_valid, a_first, a_last;
  logic [15:0] a_in, a_w, a_oa, a_oc;
  logic        b_busy, b_done, b_err, b_valid, b_first, b_last;
  logic [15:0] b_in, b_w, b_oa, b_oc;

  logic        v_busy, v_done, v_err, v_valid, v_first, v_last;
  logic [15:0] v_in, v_w, v_oa, v_oc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  conv1d_dil_sched #(.IN_CH(1), .OUT_CH(1), .KSIZE(3), .ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cfg_len_in(cfg_len),
    .cfg_stride(cfg_stride), .cfg_dilation(cfg_dilation),
    .busy(a_busy), .done(a_done), .err(a_err), .mac_valid(a_valid),
    .mac_ready(ready), .in_addr(a_in), .w_addr(a_w), .mac_first(a_first),
    .mac_last(a_last), .out_addr(a_oa), .out_count(a_oc));

  conv1d_dil_sched dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cfg_len_in(cfg_len),
    .cfg_stride(cfg_stride), .cfg_dilation(cfg_dilation),
    .busy(b_busy), .done(b_done), .err(b_err), .mac_valid(b_valid),
    .mac_ready(ready), .in_addr(b_in), .w_addr(b_w), .mac_first(b_first),
    .mac_last(b_last), .out_addr(b_oa), .out_count(b_oc));

  always_comb begin
    v_busy = a_busy; v_done = a_done; v_err = a_err; v_valid = a_valid;
    v_first = a_first; v_last = a_last; v_in = a_in; v_w = a_w;
    v_oa = a_oa; v_oc = a_oc;
    if (sel) begin
      v_busy = b_busy; v_done = b_done; v_err = b_err; v_valid = b_valid;
      v_first = b_first; v_last = b_last; v_in = b_in; v_w = b_w;
      v_oa = b_oa; v_oc = b_oc;
    end
  end

  // Expected sequences (hand-derived from the loop-order formulas).
  int ea_in[12] = '{0, 2, 4, 2, 4, 6, 4, 6, 8, 0, 0, 0};
  int ea_w[12]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0, 0};
  int ea_f[12]  = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  int ea_l[12]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
  int ea_oa[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
  int eb_in[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
  int eb_w[12]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
  int eb_f[12]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  int eb_l[12]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int eb_oa[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  int g_in[32], g_w[32], g_f[32], g_l[32], g_oa[32];
  int n_x, first_v, done_c, last_x, stall_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic run_job(input bit s, input int len, input int st, input int dl,
                         input bit rnd, input int busy_start_at);
    bit          prev_stall;
    logic [15:0] p_in, p_w, p_oa;
    logic        p_f, p_l;
    sel = s; n_x = 0; first_v = -1; done_c = -1; last_x = -1; stall_bad = 0;
    prev_stall = 1'b0;
    p_in = '0; p_w = '0; p_oa = '0; p_f = 1'b0; p_l = 1'b0;
    @(negedge clk);
    cfg_len = 16'(len); cfg_stride = 4'(st); cfg_dilation = 4'(dl);
    start = 1'b1; ready = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start = (c == busy_start_at);
      if (c == 1) begin
        cfg_len = 16'd1; cfg_stride = 4'd0; cfg_dilation = 4'd9;
      end
      if (prev_stall && (v_in !== p_in || v_w !== p_w || v_oa !== p_oa ||
                         v_first !== p_f || v_last !== p_l || v_valid !== 1'b1))
        stall_bad++;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v_valid && first_v < 0) first_v = c;
      if (v_done) begin
        done_c = c;
        break;
      end
      if (v_valid && ready && n_x < 32) begin
        g_in[n_x] = int'(v_in); g_w[n_x] = int'(v_w); g_oa[n_x] = int'(v_oa);
        g_f[n_x] = int'(v_first); g_l[n_x] = int'(v_last);
        n_x++; last_x = c;
      end
      prev_stall = v_valid && !ready;
      p_in = v_in; p_w = v_w; p_oa = v_oa; p_f = v_first; p_l = v_last;
    end
    start = 1'b0; ready = 1'b1;
  endtask

  task automatic check_seq(input string t, input int n, input int ein[12], input int ew[12],
                           input int ef[12], input int el[12], input int eoa[12]);
    chk({t, "_nops"}, n_x, n);
    for (int i = 0; i < n && i < n_x; i++) begin
      chk($sformatf("%s_in%0d", t, i), g_in[i], ein[i]);
      chk($sformatf("%s_w%0d", t, i), g_w[i], ew[i]);
      chk($sformatf("%s_first%0d", t, i), g_f[i], ef[i]);
      chk($sformatf("%s_last%0d", t, i), g_l[i], el[i]);
      chk($sformatf("%s_oa%0d", t, i), g_oa[i], eoa[i]);
    end
  endtask

  task automatic check_end(input string t, input int cnt, input int e);
    chk({t, "_done_after_last"}, done_c, last_x + 1);
    chk({t, "_out_count"}, v_oc, cnt);
    chk({t, "_err"}, v_err, e);
    @(negedge clk);
    chk({t, "_done_pulse_width"}, v_done, 0);
    chk({t, "_busy_after"}, v_busy, 0);
    chk({t, "_out_count_held"}, v_oc, cnt);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    sel = 1'b0;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_first_last", {a_first, a_last}, 0);
    chk("rst_in_w", {a_in, a_w}, 0);
    chk("rst_oa_oc", {a_oa, a_oc}, 0);
    chk("rst_b_busy_valid", {b_busy, b_valid}, 0);
    @(negedge clk);
    rst = 1'b0;

    // A: len10 stride2 dil2, always ready
    run_job(1'b0, 10, 2, 2, 1'b0, 0);
    chk("a_first_valid_cyc", first_v, 2);
    check_seq("a", 9, ea_in, ea_w, ea_f, ea_l, ea_oa);
    check_end("a", 3, 0);

    // B: invalid, span 4 == len 4
    run_job(1'b1, 4, 1, 2, 1'b0, 0);
    chk("binv_no_valid", first_v, -1);
    chk("binv_nops", n_x, 0);
    chk("binv_done_cyc", done_c, 2);
    chk("binv_err", v_err, 1);
    @(negedge clk);
    chk("binv_err_held", v_err, 1);
    chk("binv_busy_after", v_busy, 0);

    // B: defaults len3 stride1 dil1; err clears on accepted start
    run_job(1'b1, 3, 1, 1, 1'b0, 0);
    chk("b_first_valid_cyc", first_v, 2);
    check_seq("b", 12, eb_in, eb_w, eb_f, eb_l, eb_oa);
    check_end("b", 2, 0);

    // A: stride 0 is invalid
    run_job(1'b0, 10, 0, 2, 1'b0, 0);
    chk("as0_nops", n_x, 0);
    chk("as0_done_cyc", done_c, 2);
    chk("as0_err", v_err, 1);

    // A: span == len-1 is the tightest valid case (one output)
    run_job(1'b0, 5, 1, 2, 1'b0, 0);
    check_seq("aedge", 3, ea_in, ea_w, ea_f, ea_l, ea_oa);
    check_end("aedge", 1, 0);

    // A: random back-pressure
    run_job(1'b0, 10, 2, 2, 1'b1, 0);
    check_seq("arnd", 9, ea_in, ea_w, ea_f, ea_l, ea_oa);
    chk("arnd_stall_stable", stall_bad, 0);
    check_end("arnd", 3, 0);

    // A: start pulsed while busy with a bad config must be ignored
    run_job(1'b0, 10, 2, 2, 1'b0, 4);
    check_seq("abusy", 9, ea_in, ea_w, ea_f, ea_l, ea_oa);
    check_end("abusy", 3, 0);

    // A: reset mid-RUN, then clean restart
    sel = 1'b0;
    @(negedge clk);
    cfg_len = 16'd10; cfg_stride = 4'd2; cfg_dilation = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_valid_before_rst", a_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy_valid", {a_busy, a_valid, a_done, a_err}, 0);
    chk("mid_rst_flags", {a_first, a_last}, 0);
    chk("mid_rst_addrs", {a_in, a_w}, 0);
    chk("mid_rst_counts", {a_oa, a_oc}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_job(1'b0, 10, 2, 2, 1'b0, 0);
    chk("arst_first_valid_cyc", first_v, 2);
    check_seq("arst", 9, ea_in, ea_w, ea_f, ea_l, ea_oa);
    check_end("arst", 3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
